// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared state encoding and address helpers for the KNN training loader
package knn_pkg;

  typedef logic [2:0] knn_state_t;

  localparam knn_state_t ST_IDLE       = 3'd0;
  localparam knn_state_t ST_LOAD_QUERY = 3'd1;
  localparam knn_state_t ST_READY      = 3'd2;
  localparam knn_state_t ST_FETCH      = 3'd3;
  localparam knn_state_t ST_DONE       = 3'd4;

  // One type word followed by the feature words.
  function automatic int unsigned words_per_sample(input int unsigned mn);
    return mn + 1;
  endfunction

  function automatic int unsigned sample_base(input int unsigned s, input int unsigned mn,
                                              input int unsigned qbase);
    return qbase + mn + s * words_per_sample(mn);
  endfunction

endpackage

// File: rtl/knn_burst_reader.sv
// rtl/knn_burst_reader.sv - issues count sequential reads from base and tags each returned word
module knn_burst_reader #(
  parameter int W      = 8,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  input  logic [W-1:0]      mem_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [CNT_W-1:0]  rsp_index,
  output logic              rsp_last
);

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  rsp_idx_q, rsp_idx_d;
  logic              rsp_last_q, rsp_last_d;
  logic              issue_last;

  assign issue_last = (idx_q == cnt_q - CNT_W'(1));

  always_comb begin
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (go) begin
      rd_en_d = (count != '0);
      addr_d  = base;
      idx_d   = '0;
      cnt_d   = count;
    end else if (rd_en_q) begin
      if (issue_last) begin
        rd_en_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        idx_d  = idx_q + CNT_W'(1);
      end
    end
    // Response tags trail the strobe by one cycle, matching the RAM read latency.
    rsp_valid_d = rd_en_q;
    rsp_idx_d   = idx_q;
    rsp_last_d  = rd_en_q && issue_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = mem_rd_data;
  assign rsp_index = rsp_idx_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: rtl/knn_training_loader.sv
// rtl/knn_training_loader.sv - loads the query then serves one training sample per request
// Build option KNN_LOADER_WRAP_EN: wrap to sample 0 after the last sample instead of stopping.
module knn_training_loader
  import knn_pkg::*;
#(
  parameter int M           = 4,
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int TYPE_W      = 2,
  parameter int NUM_SAMPLES = 16,
  parameter int ADDR_W      = 12,
  parameter int QUERY_BASE  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           data_request,
  input  logic [W-1:0]                   mem_rd_data,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [M*N-1:0][W-1:0]          input_data,
  output logic                           query_valid,
  output logic [M*N-1:0][W-1:0]          training_data,
  output logic [TYPE_W-1:0]              training_data_type,
  output logic                           read_done,
  output logic [$clog2(NUM_SAMPLES)-1:0] sample_index,
  output logic                           samples_done,
  output logic                           busy
);

  localparam int MN     = M * N;
  localparam int WPS    = words_per_sample(MN);
  localparam int CNT_W  = $clog2(WPS + 1);
  localparam int SIDX_W = $clog2(NUM_SAMPLES);
  localparam longint unsigned LAST_END =
    64'(sample_base(NUM_SAMPLES - 1, MN, QUERY_BASE)) + 64'(WPS);
  localparam longint unsigned ADDR_SPACE = 64'd1 << ADDR_W;

  if (LAST_END > ADDR_SPACE) begin : g_bad_layout
    $error("knn_training_loader: training set does not fit in the address space");
  end

  knn_state_t               state_q, state_d;
  logic                     query_valid_q, query_valid_d;
  logic                     samples_done_q, samples_done_d;
  logic                     read_done_q, read_done_d;
  logic [SIDX_W-1:0]        sample_index_q, sample_index_d;
  logic [TYPE_W-1:0]        type_q, type_d;
  logic [MN-1:0][W-1:0]     input_q, input_d;
  logic [MN-1:0][W-1:0]     train_q, train_d;

  logic                     burst_go;
  logic [ADDR_W-1:0]        burst_base;
  logic [CNT_W-1:0]         burst_count;
  logic                     rsp_valid;
  logic [W-1:0]             rsp_data;
  logic [CNT_W-1:0]         rsp_index;
  logic                     rsp_last;
  logic                     last_sample;

  assign last_sample = (sample_index_q == SIDX_W'(NUM_SAMPLES - 1));

  knn_burst_reader #(
    .W      (W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_reader (
    .clk         (clk),
    .rst         (rst),
    .go          (burst_go),
    .base        (burst_base),
    .count       (burst_count),
    .mem_rd_data (mem_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_index   (rsp_index),
    .rsp_last    (rsp_last)
  );

  always_comb begin
    state_d        = state_q;
    query_valid_d  = query_valid_q;
    read_done_d    = 1'b0;
    sample_index_d = sample_index_q;
    type_d         = type_q;
    input_d        = input_q;
    train_d        = train_q;
`ifdef KNN_LOADER_WRAP_EN
    samples_done_d = 1'b0;
`else
    samples_done_d = samples_done_q;
`endif
    burst_go    = 1'b0;
    burst_base  = ADDR_W'(QUERY_BASE);
    burst_count = CNT_W'(MN);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_LOAD_QUERY;
          burst_go       = 1'b1;
          query_valid_d  = 1'b0;
          samples_done_d = 1'b0;
        end
      end
      ST_LOAD_QUERY: begin
        if (rsp_valid) begin
          for (int k = 0; k < MN; k++) begin
            if (rsp_index == CNT_W'(k)) input_d[k] = rsp_data;
          end
          if (rsp_last) begin
            query_valid_d  = 1'b1;
            sample_index_d = '0;
          end
        end
        if (query_valid_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (start) begin
          state_d        = ST_LOAD_QUERY;
          burst_go       = 1'b1;
          query_valid_d  = 1'b0;
          samples_done_d = 1'b0;
        end else if (data_request) begin
          state_d     = ST_FETCH;
          burst_go    = 1'b1;
          burst_base  = ADDR_W'(sample_base(32'(sample_index_q), MN, QUERY_BASE));
          burst_count = CNT_W'(WPS);
        end
      end
      ST_FETCH: begin
        if (rsp_valid) begin
          if (rsp_index == '0) type_d = rsp_data[TYPE_W-1:0];
          for (int k = 0; k < MN; k++) begin
            if (rsp_index == CNT_W'(k + 1)) train_d[k] = rsp_data;
          end
          if (rsp_last) begin
            read_done_d    = 1'b1;
            sample_index_d = last_sample ? '0 : sample_index_q + SIDX_W'(1);
            if (last_sample) samples_done_d = 1'b1;
          end
        end
        // Stay one extra cycle so read_done is seen before a new request is accepted.
        if (read_done_q) begin
`ifdef KNN_LOADER_WRAP_EN
          state_d = ST_READY;
`else
          state_d = samples_done_q ? ST_DONE : ST_READY;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      query_valid_q  <= 1'b0;
      samples_done_q <= 1'b0;
      read_done_q    <= 1'b0;
      sample_index_q <= '0;
      type_q         <= '1;
      input_q        <= '1;
      train_q        <= '1;
    end else begin
      state_q        <= state_d;
      query_valid_q  <= query_valid_d;
      samples_done_q <= samples_done_d;
      read_done_q    <= read_done_d;
      sample_index_q <= sample_index_d;
      type_q         <= type_d;
      input_q        <= input_d;
      train_q        <= train_d;
    end
  end

  assign input_data         = input_q;
  assign query_valid        = query_valid_q;
  assign training_data      = train_q;
  assign training_data_type = type_q;
  assign read_done          = read_done_q;
  assign sample_index       = sample_index_q;
  assign samples_done       = samples_done_q;
  assign busy               = (state_q == ST_LOAD_QUERY) || (state_q == ST_FETCH);

endmodule

// File: tb/tb_knn_training_loader.sv
// tb/tb_knn_training_loader.sv - directed self-checking bench for knn_training_loader
module tb_knn_training_loader;

  localparam int M      = 2;
  localparam int N      = 2;
  localparam int W      = 8;
  localparam int TYPE_W = 2;
  localparam int NS     = 3;
  localparam int ADDR_W = 12;
  localparam int QB     = 0;
  localparam int MN     = M * N;
  localparam int SIW    = $clog2(NS);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  data_request;
  logic [W-1:0]          mem_rd_data;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [MN-1:0][W-1:0]  input_data;
  logic                  query_valid;
  logic [MN-1:0][W-1:0]  training_data;
  logic [TYPE_W-1:0]     training_data_type;
  logic                  read_done;
  logic [SIW-1:0]        sample_index;
  logic                  samples_done;
  logic                  busy;

  knn_training_loader #(
    .M(M), .N(N), .W(W), .TYPE_W(TYPE_W), .NUM_SAMPLES(NS), .ADDR_W(ADDR_W), .QUERY_BASE(QB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .data_request       (data_request),
    .mem_rd_data        (mem_rd_data),
    .mem_rd_en          (mem_rd_en),
    .mem_addr           (mem_addr),
    .input_data         (input_data),
    .query_valid        (query_valid),
    .training_data      (training_data),
    .training_data_type (training_data_type),
    .read_done          (read_done),
    .sample_index       (sample_index),
    .samples_done       (samples_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:31];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[4:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic            rd_en_prev = 1'b0;
  logic            qv_prev = 1'b0;
  int              n_reads = 0;
  int              qv_rise_cyc = -1;
  logic [31:0]     snap_data[$];
  logic [1:0]      snap_type[$];
  logic [SIW-1:0]  snap_idx[$];
  logic            snap_sd[$];
  int              burst_addr[$];
  int              burst_cyc[$];

  always @(negedge clk) begin
    if (read_done) begin
      snap_data.push_back(training_data);
      snap_type.push_back(training_data_type);
      snap_idx.push_back(sample_index);
      snap_sd.push_back(samples_done);
    end
    if (mem_rd_en) n_reads++;
    if (mem_rd_en && !rd_en_prev) begin
      burst_addr.push_back(int'(mem_addr));
      burst_cyc.push_back(cyc);
    end
    if (query_valid && !qv_prev) qv_rise_cyc = cyc;
    rd_en_prev = mem_rd_en;
    qv_prev    = query_valid;
  end

  task automatic clear_logs();
    snap_data.delete();
    snap_type.delete();
    snap_idx.delete();
    snap_sd.delete();
    burst_addr.delete();
    burst_cyc.delete();
    n_reads = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int n0, input int limit, output int n);
    n = n0;
    while (!read_done && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic wait_qv(input int n0, input int limit, output int n);
    n = n0;
    while (!query_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_rd_en"}, mem_rd_en, 0);
    check_eq({pfx, "_addr"}, mem_addr, 0);
    check_eq({pfx, "_read_done"}, read_done, 0);
    check_eq({pfx, "_qv"}, query_valid, 0);
    check_eq({pfx, "_sdone"}, samples_done, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_sidx"}, sample_index, 0);
    check_eq({pfx, "_input"}, input_data, 32'hFFFF_FFFF);
    check_eq({pfx, "_train"}, training_data, 32'hFFFF_FFFF);
    check_eq({pfx, "_type"}, training_data_type, 2'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    data_request = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'd1;  mem[1] = 8'd2;  mem[2] = 8'd3;  mem[3] = 8'd4;
    mem[4] = 8'd2;  mem[5] = 8'd10; mem[6] = 8'd11; mem[7] = 8'd12; mem[8] = 8'd13;
    mem[9] = 8'd1;  mem[10] = 8'd20; mem[11] = 8'd21; mem[12] = 8'd22; mem[13] = 8'd23;
    mem[14] = 8'd3; mem[15] = 8'd30; mem[16] = 8'd31; mem[17] = 8'd32; mem[18] = 8'd33;

    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Query load: start in cycle 0, query_valid expected in cycle 6.
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_load", busy, 1);
    wait_qv(1, 20, n);
    check_eq("query_latency", n, 6);
    check_eq("query_data", input_data, 32'h0403_0201);
    check_eq("query_bursts", burst_addr.size(), 1);
    if (burst_addr.size() > 0) check_eq("query_base", burst_addr[0], 0);
    step();
    check_eq("ready_not_busy", busy, 0);
    check_eq("ready_sidx", sample_index, 0);

    // Single fetch of sample 0.
    clear_logs();
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    wait_rd(1, 30, n);
    check_eq("fetch_latency", n, 7);
    check_eq("fetch_data", training_data, 32'h0D0C_0B0A);
    check_eq("fetch_type", training_data_type, 2'd2);
    check_eq("fetch_sidx", sample_index, 1);
    check_eq("fetch_reads", n_reads, 5);
    check_eq("fetch_bursts", burst_addr.size(), 1);
    if (burst_addr.size() > 0) check_eq("fetch_base", burst_addr[0], 4);
    step();
    check_eq("read_done_pulse", read_done, 0);
    check_eq("fetch_back_ready", busy, 0);

    // Start wins over request in READY, then the held request drains every sample.
    clear_logs();
    start = 1'b1;
    data_request = 1'b1;
    step();
    start = 1'b0;
    check_eq("reload_qv_low", query_valid, 0);
    repeat (34) step();
    data_request = 1'b0;
    repeat (10) step();
    if (burst_cyc.size() > 1) check_eq("fetch_after_qv", burst_cyc[1] > qv_rise_cyc, 1);
    if (burst_addr.size() > 3) begin
      check_eq("held_base0", burst_addr[1], 4);
      check_eq("held_base1", burst_addr[2], 9);
      check_eq("held_base2", burst_addr[3], 14);
    end
    if (snap_data.size() > 2) begin
      check_eq("held_s0_data", snap_data[0], 32'h0D0C_0B0A);
      check_eq("held_s0_type", snap_type[0], 2'd2);
      check_eq("held_s0_sidx", snap_idx[0], 1);
      check_eq("held_s0_sdone", snap_sd[0], 0);
      check_eq("held_s1_data", snap_data[1], 32'h1716_1514);
      check_eq("held_s1_type", snap_type[1], 2'd1);
      check_eq("held_s1_sidx", snap_idx[1], 2);
      check_eq("held_s2_data", snap_data[2], 32'h2120_1F1E);
      check_eq("held_s2_type", snap_type[2], 2'd3);
      check_eq("held_s2_sdone", snap_sd[2], 1);
    end
`ifdef KNN_LOADER_WRAP_EN
    check_eq("wrap_bursts", burst_addr.size(), 5);
    if (burst_addr.size() > 4) check_eq("wrap_base", burst_addr[4], 4);
    check_eq("wrap_read_dones", snap_data.size(), 4);
    if (snap_data.size() > 3) check_eq("wrap_data", snap_data[3], 32'h0D0C_0B0A);
    if (snap_idx.size() > 2) check_eq("wrap_sidx", snap_idx[2], 0);
    check_eq("wrap_sdone_pulse", samples_done, 0);
`else
    check_eq("done_bursts", burst_addr.size(), 4);
    check_eq("done_read_dones", snap_data.size(), 3);
    check_eq("done_sdone", samples_done, 1);
`endif
    check_eq("held_end_busy", busy, 0);

    // Start during FETCH is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_qv(1, 20, n);
    step();
    check_eq("restart_sdone", samples_done, 0);
    clear_logs();
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rd(3, 30, n);
    check_eq("ign_start_latency", n, 7);
    check_eq("ign_start_sidx", sample_index, 1);
    check_eq("ign_start_data", training_data, 32'h0D0C_0B0A);
    check_eq("ign_start_qv", query_valid, 1);
    check_eq("ign_start_bursts", burst_addr.size(), 1);
    step();
    check_eq("ign_start_ready", busy, 0);

    // Reset in the middle of fetching sample 1.
    clear_logs();
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("midrst");
    repeat (12) step();
    check_eq("midrst_no_read_done", snap_data.size(), 0);
    check_eq("midrst_idle_rd_en", mem_rd_en, 0);

    // A request raised in IDLE stays pending until the query is loaded.
    clear_logs();
    data_request = 1'b1;
    repeat (3) step();
    check_eq("idle_ignores_req", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rd(1, 40, n);
    data_request = 1'b0;
    check_eq("pending_req_served", read_done, 1);
    check_eq("pending_req_data", training_data, 32'h0D0C_0B0A);
    check_eq("pending_req_type", training_data_type, 2'd2);
    repeat (4) step();
    check_eq("pending_single_fetch", snap_data.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_training_loader.md
# knn_training_loader

Memory-side responder for the KNN distance pipeline. It loads the query vector from a word-addressed synchronous memory, then serves one training sample per `data_request` from the distance calculator. For each sample it fetches the type word and M*N feature words, assembles `training_data`/`training_data_type`, and pulses `read_done`. It sits between the training-set RAM/ROM and the KNN system top level, driving that level's `read_done`, `training_data`, `training_data_type` and `input_data`.

## Interface
- `M`, 4: feature rows.
- `N`, 4: feature columns.
- `W`, 8: feature/memory word width.
- `TYPE_W`, 2: class label width; the low TYPE_W bits of the type word.
- `NUM_SAMPLES`, 16: training samples in memory (L).
- `ADDR_W`, 12: memory address width.
- `QUERY_BASE`, 0: word address of the query vector.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: load the query and rewind to sample 0.
- `data_request` in 1: level request for the next training sample.
- `mem_rd_data` in W: read data, valid the cycle after `mem_rd_en`.
- `mem_rd_en` out 1: memory read strobe (registered).
- `mem_addr` out ADDR_W: memory address (registered).
- `input_data` out W x M*N: query vector.
- `query_valid` out 1: query loaded.
- `training_data` out W x M*N: current sample features.
- `training_data_type` out TYPE_W: current sample label.
- `read_done` out 1: one-cycle pulse when the sample is complete.
- `sample_index` out clog2(NUM_SAMPLES) bits: index of the next sample to serve.
- `samples_done` out 1: all samples served.
- `busy` out 1: high in LOAD_QUERY and FETCH.

## Operation
- Memory layout:
  - Query occupies QUERY_BASE .. QUERY_BASE+M*N-1.
  - Sample s base = QUERY_BASE + M*N + s*(M*N+1).
  - At the sample base: the type word first, then M*N features in row-major order.
- FSM states: IDLE, LOAD_QUERY, READY, FETCH, DONE.
- IDLE:
  - `start` moves to LOAD_QUERY.
  - `data_request` is ignored but stays pending, because it is a level.
- LOAD_QUERY:
  - Reads M*N words into `input_data[0..M*N-1]`.
  - Then sets `query_valid`, sets `sample_index`=0, and moves to READY.
- READY:
  - `data_request`=1 moves to FETCH.
  - `start` has priority over `data_request` and reloads the query.
- FETCH:
  - Issues M*N+1 consecutive addresses from the sample base.
  - The first returned word gives `training_data_type`; word k+1 gives `training_data[k]`.
  - After the last capture: pulse `read_done`, increment `sample_index`, return to READY.
  - When the served sample was NUM_SAMPLES-1, go to DONE instead and set `samples_done`.
- DONE:
  - Requests are ignored.
  - `start` returns to LOAD_QUERY and clears `samples_done`.
- `start` during LOAD_QUERY or FETCH is ignored.
- `data_request` still high the cycle after `read_done` counts as a new request. The consumer must drop it to avoid a double fetch.
- `training_data` is updated word by word during FETCH. It is valid from `read_done` until the next FETCH begins.
- Address arithmetic is unsigned ADDR_W bits. The parameter check requires the last sample to fit within 2^ADDR_W.
- Reset values: FSM=IDLE, `mem_rd_en`=0, `mem_addr`=0, `read_done`=0, `query_valid`=0, `samples_done`=0, `busy`=0, `sample_index`=0. All `input_data`, `training_data` and `training_data_type` entries reset to all-ones.
- Reset during LOAD_QUERY or FETCH aborts immediately. Memory data returning in the following cycle is discarded.

## Timing
- Request accepted in cycle t (READY, `data_request`=1).
- `mem_rd_en`=1 in cycles t+1 .. t+1+M*N.
- Data is captured at the ends of cycles t+2 .. t+2+M*N.
- `read_done` is high in cycle t+3+M*N. Latency is M*N+3 cycles.
- Query load: `start` in cycle t gives `query_valid` high in cycle t+3+M*N-1.
- The earliest next request accepted is in cycle t+4+M*N (READY).

## Configuration
- `KNN_LOADER_WRAP_EN` defined:
  - After sample NUM_SAMPLES-1, `sample_index` wraps to 0 and the FSM returns to READY rather than DONE.
  - `samples_done` pulses for one cycle, coincident with that `read_done`.
- Not defined: DONE is terminal until `start`, and `samples_done` is a level.

## Structure
- Package `knn_pkg` holds:
  - the FSM state enum;
  - a `sample_base(s)` address function;
  - the words-per-sample constant M*N+1.
- Sub-module `knn_burst_reader` issues `count` sequential reads from `base`. It returns each word with its word index and a last flag. It is used by both LOAD_QUERY and FETCH.

## Test plan
All scenarios use M=N=2, W=8, TYPE_W=2, NUM_SAMPLES=3, QUERY_BASE=0.
- Query load: memory[0..3]=1,2,3,4, `start` in cycle 0 → `input_data`={1,2,3,4} and `query_valid`=1 in cycle 6.
- Single fetch: memory[4..8]=2,10,11,12,13, request in cycle t → `read_done` in cycle t+7, `training_data`={10,11,12,13}, type=2, `sample_index`=1.
- Held request: `data_request` held high → three back-to-back fetches of samples 0, 1, 2 (bases 4, 9, 14), then DONE and `samples_done`=1. A fourth request gets no `read_done`. With `KNN_LOADER_WRAP_EN`, the fourth request fetches base 4 again.
- Start priority: `start` and `data_request` both high in READY → query reload, and the fetch occurs after `query_valid`.
- Reset mid-fetch: `rst` at cycle t+3 → next cycle `mem_rd_en`=0, state IDLE, all outputs at reset values, no `read_done`.
- Ignored start: `start` pulsed during FETCH → fetch completes normally and `sample_index` advances.
